// File: rtl/dm_bytelane.sv
// Byte-lane data memory for the M stage: word/half/byte loads and stores, alignment check,
// and a sequential clear sweep that stalls the pipeline. Optional store trace: DM_TRACE_EN.
module dm_bytelane #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [2:0]  mode,
    input  logic        clr,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        busy
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic {StClear, StReady} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                busy_q;
    logic [31:0]         mem [Depth];

    logic [ADDR_W-1:0]   idx;
    logic [1:0]          lane;
    logic [31:0]         rword;
    logic                mode_half;
    logic                mode_byte;
    logic                mode_bad;
    logic [15:0]         half_val;
    logic [7:0]          byte_val;
    logic [31:0]         load_val;
    logic [31:0]         merged;
    logic                store_en;
    logic                sweep_en;
    logic                unused_bits;

    assign idx   = addr[ADDR_W+1:2];
    assign lane  = addr[1:0];
    assign rword = mem[idx];
    assign busy  = busy_q;

    // pc only feeds the trace; upper address bits are outside the array
    assign unused_bits = ^{pc, addr[31:ADDR_W+2]};

    always_comb begin
        mode_half = (mode == 3'b001) || (mode == 3'b010);
        mode_byte = (mode == 3'b011) || (mode == 3'b100);
        mode_bad  = (mode > 3'b100);
        misalign  = mode_bad
                  || ((mode == 3'b000) && (lane != 2'b00))
                  || (mode_half && lane[0]);
    end

    always_comb begin
        half_val = lane[1] ? rword[31:16] : rword[15:0];
        byte_val = rword[7:0];
        case (lane)
            2'd0:    byte_val = rword[7:0];
            2'd1:    byte_val = rword[15:8];
            2'd2:    byte_val = rword[23:16];
            default: byte_val = rword[31:24];
        endcase
        load_val = '0;
        case (mode)
            3'b000:  load_val = rword;
            3'b001:  load_val = {{16{half_val[15]}}, half_val};
            3'b010:  load_val = {16'h0000, half_val};
            3'b011:  load_val = {{24{byte_val[7]}}, byte_val};
            3'b100:  load_val = {24'h000000, byte_val};
            default: load_val = '0;
        endcase
        rdata = (misalign || busy_q) ? '0 : load_val;
    end

    always_comb begin
        merged = rword;
        if (mode == 3'b000) begin
            merged = wdata;
        end else if (mode_half) begin
            if (lane[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
        end else if (mode_byte) begin
            case (lane)
                2'd0:    merged[7:0]   = wdata[7:0];
                2'd1:    merged[15:8]  = wdata[7:0];
                2'd2:    merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end
    end

    // No array writes at all while reset is held; the array keeps its contents.
    assign store_en = reset && we && !busy_q && !misalign;
    assign sweep_en = reset && busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= (INIT_CLEAR != 0) ? StClear : StReady;
            busy_q  <= (INIT_CLEAR != 0);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_q <= StReady;
                        busy_q  <= 1'b0;
                    end
                end
                StReady: begin
                    if (clr) begin
                        state_q <= StClear;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= StReady;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_en) begin
            mem[cnt_q] <= '0;
        end else if (store_en) begin
            mem[idx] <= merged;
`ifdef DM_TRACE_EN
            $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
`endif
        end
    end

endmodule
